// File: rtl/three_xor_pkg.sv
// -----------------------------------------------------------------------------
// three_xor_pkg
// Shared constants and the result record for the three_xor_parity pipeline.
//   DEFAULT_WIDTH / DEFAULT_STAGES : parameter defaults for the top level
//   MAX_WIDTH / MAX_STAGES         : legal upper bounds of those parameters
//   xor_result_t                   : {valid, data, par} at the default width
// -----------------------------------------------------------------------------
package three_xor_pkg;

  localparam int DEFAULT_WIDTH  = 1;
  localparam int DEFAULT_STAGES = 1;
  localparam int MAX_WIDTH      = 64;
  localparam int MAX_STAGES     = 4;

  // Field order of one pipeline slot. The top level declares the same layout
  // at its own WIDTH, since a package typedef cannot follow a module parameter.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
    logic                     par;
  } xor_result_t;

endpackage : three_xor_pkg

// File: rtl/xor3_stage.sv
// -----------------------------------------------------------------------------
// xor3_stage
// One pipeline register slot: valid always advances, data/parity load only
// when the incoming slot is valid, so they hold across idle cycles.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low clear of every register in the slot
//   valid_i  : incoming slot is valid
//   data_i   : incoming result word (WIDTH bits)
//   par_i    : incoming reduction parity of data_i
//   valid_o  : registered valid
//   data_o   : registered result word
//   par_o    : registered parity
// -----------------------------------------------------------------------------
module xor3_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             par_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;
  logic             par_d,   par_q;

  // NOTE: every signal gets a default first so no path through this block
  // leaves a value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid_d = valid_i;
    data_d  = data_q;
    par_d   = par_q;
    if (valid_i) begin
      data_d = data_i;
      par_d  = par_i;
    end
  end

  // NOTE: non-blocking assignments here so every register samples its
  // next-state at the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign par_o   = par_q;

endmodule : xor3_stage

// File: rtl/three_xor_parity.sv
// -----------------------------------------------------------------------------
// three_xor_parity
// Pipelined bitwise d = a ^ b ^ c with aligned reduction parity and a valid
// strobe. Latency is STAGES cycles; one operand set accepted per cycle.
// Parameters: WIDTH (1..64), STAGES (1..4).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset, clears every stage
//   in_valid  : a/b/c form a valid operand set this cycle
//   a, b, c   : operands (WIDTH bits)
//   out_valid : d/d_par hold a fresh result
//   d         : a^b^c of the sample taken STAGES cycles earlier
//   d_par     : ^d (1 = odd number of set bits)
//   d_comb    : a^b^c with zero latency, only when THREE_XOR_COMB_OUT_EN
//               is defined (unaffected by rst_n and in_valid)
// -----------------------------------------------------------------------------
module three_xor_parity
  import three_xor_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] d,
  output logic             d_par
`ifdef THREE_XOR_COMB_OUT_EN
  ,
  output logic [WIDTH-1:0] d_comb
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("three_xor_parity: WIDTH out of range");
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("three_xor_parity: STAGES out of range");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             par;
  } result_t;

  logic [WIDTH-1:0] xor_w;
  result_t          slot [STAGES+1];

  assign xor_w = a ^ b ^ c;

  // Slot 0 is the unregistered result; parity is taken here so it travels
  // with the data and stays aligned through every stage.
  assign slot[0] = '{valid: in_valid, data: xor_w, par: ^xor_w};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    xor3_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (slot[s].valid),
      .data_i  (slot[s].data),
      .par_i   (slot[s].par),
      .valid_o (slot[s+1].valid),
      .data_o  (slot[s+1].data),
      .par_o   (slot[s+1].par)
    );
  end

  assign out_valid = slot[STAGES].valid;
  assign d         = slot[STAGES].data;
  assign d_par     = slot[STAGES].par;

`ifdef THREE_XOR_COMB_OUT_EN
  assign d_comb = xor_w;
`endif

endmodule : three_xor_parity

// File: tb/tb_three_xor_parity.sv
// -----------------------------------------------------------------------------
// tb_three_xor_parity
// Two instances: (WIDTH=1, STAGES=1) and (WIDTH=8, STAGES=3). A delay-line
// model tracks the expected output of each and is compared every cycle;
// directed steps add literal expectations from hand calculation.
// -----------------------------------------------------------------------------
module tb_three_xor_parity;

  localparam int S8 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid1, in_valid8;
  logic [0:0] a1, b1, c1;
  logic [7:0] a8, b8, c8;
  logic       out_valid1, out_valid8;
  logic [0:0] d1;
  logic [7:0] d8;
  logic       d_par1, d_par8;
`ifdef THREE_XOR_COMB_OUT_EN
  logic [0:0] d_comb1;
  logic [7:0] d_comb8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  three_xor_parity #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .c         (c1),
    .out_valid (out_valid1),
    .d         (d1),
    .d_par     (d_par1)
`ifdef THREE_XOR_COMB_OUT_EN
    ,
    .d_comb    (d_comb1)
`endif
  );

  three_xor_parity #(.WIDTH(8), .STAGES(S8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .c         (c8),
    .out_valid (out_valid8),
    .d         (d8),
    .d_par     (d_par8)
`ifdef THREE_XOR_COMB_OUT_EN
    ,
    .d_comb    (d_comb8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: each accepted edge pushes {valid, a^b^c} into a delay line that is
  // STAGES-1 slots deep, so the slot popped at the same edge is the sample the
  // DUT shows after that edge. The last valid value popped is what d holds.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       v;
    logic [7:0] d;
  } slot_t;

  slot_t      q1[$];
  slot_t      q8[$];
  logic       m1_v, m8_v, m1_par, m8_par;
  logic [7:0] m1_d, m8_d;
  bit         model_live = 1'b0;

  always @(posedge clk) begin
    slot_t s;
    if (!rst_n) begin
      q1.delete();
      q8.delete();
      for (int k = 0; k < S8 - 1; k++) q8.push_back('{v: 1'b0, d: 8'h00});
      m1_v = 1'b0; m1_d = 8'h00;
      m8_v = 1'b0; m8_d = 8'h00;
    end else begin
      q1.push_back('{v: in_valid1, d: {7'b0, a1 ^ b1 ^ c1}});
      s = q1.pop_front();
      m1_v = s.v;
      if (s.v) m1_d = s.d;
      q8.push_back('{v: in_valid8, d: a8 ^ b8 ^ c8});
      s = q8.pop_front();
      m8_v = s.v;
      if (s.v) m8_d = s.d;
    end
    m1_par = ($countones(m1_d) % 2) == 1;
    m8_par = ($countones(m8_d) % 2) == 1;
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cmp1.out_valid", 64'(out_valid1), 64'(m1_v));
      check("cmp1.d",         64'(d1),         64'(m1_d[0]));
      check("cmp1.d_par",     64'(d_par1),     64'(m1_par));
      check("cmp8.out_valid", 64'(out_valid8), 64'(m8_v));
      check("cmp8.d",         64'(d8),         64'(m8_d));
      check("cmp8.d_par",     64'(d_par8),     64'(m8_par));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] tt_exp;
  logic [7:0] pat;

  initial begin
    tt_exp = 8'h96;  // bit i = expected d for abc = i

    // Reset held with all-ones operands and in_valid asserted.
    rst_n = 1'b0;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst1.out_valid", 64'(out_valid1), 64'd0);
      check("rst1.d",         64'(d1),         64'd0);
      check("rst1.d_par",     64'(d_par1),     64'd0);
      check("rst8.out_valid", 64'(out_valid8), 64'd0);
      check("rst8.d",         64'(d8),         64'd0);
      check("rst8.d_par",     64'(d_par8),     64'd0);
`ifdef THREE_XOR_COMB_OUT_EN
      check("rst1.d_comb", 64'(d_comb1), 64'd1);
      check("rst8.d_comb", 64'(d_comb8), 64'hFF);
`endif
    end

    // Truth table on the 1-bit instance; wide vector on the 8-bit one.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pat = 8'(i);
      in_valid1 = 1'b1;
      a1 = pat[2]; b1 = pat[1]; c1 = pat[0];
      if (i == 0) begin
        in_valid8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC; c8 = 8'hAA;
      end else begin
        in_valid8 = 1'b0; a8 = 8'h0F; b8 = 8'h00; c8 = 8'h00;
      end
`ifdef THREE_XOR_COMB_OUT_EN
      #1 check("tt.d_comb", 64'(d_comb1), 64'(tt_exp[i]));
`endif
      tick();
      check("tt.out_valid", 64'(out_valid1), 64'd1);
      check("tt.d",         64'(d1),         64'(tt_exp[i]));
      check("tt.d_par",     64'(d_par1),     64'(tt_exp[i]));
      if (i < S8 - 1) check("wide.early_valid", 64'(out_valid8), 64'd0);
      if (i == S8 - 1) begin
        check("wide.out_valid", 64'(out_valid8), 64'd1);
        check("wide.d",         64'(d8),         64'h96);
        check("wide.d_par",     64'(d_par8),     64'd0);
        check("model8.d",       64'(m8_d),       64'h96);
      end
      if (i == S8) check("wide.hold_d", 64'(d8), 64'h96);
    end

    // Valid gaps: invalid slots carry different operands that must not load.
    for (int i = 0; i < 6; i++) begin
      in_valid1 = (i % 2 == 0);
      a1 = 1'b1; b1 = (i % 2 == 0) ? 1'b0 : 1'b1; c1 = 1'b0;
      in_valid8 = (i % 2 == 0);
      a8 = (i % 2 == 0) ? 8'h01 : 8'hFF; b8 = 8'h02; c8 = 8'h04;
      tick();
      check("gap.out_valid", 64'(out_valid1), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("gap.d",         64'(d1),         64'd1);
      check("model1.d",      64'(m1_d),       64'd1);
    end
    check("gap8.d",     64'(d8),     64'h07);
    check("gap8.d_par", 64'(d_par8), 64'd1);

    // Mid-stream reset with samples in flight; reset also overrides in_valid.
    for (int i = 0; i < 3; i++) begin
      in_valid8 = 1'b1; a8 = 8'(8'h11 * (i + 1)); b8 = 8'h3C; c8 = 8'h00;
      in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    tick();
    check("mrst.out_valid8", 64'(out_valid8), 64'd0);
    check("mrst.d8",         64'(d8),         64'd0);
    check("mrst.out_valid1", 64'(out_valid1), 64'd0);
    rst_n = 1'b1;
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst.idle_valid8", 64'(out_valid8), 64'd0);
      check("mrst.idle_d8",     64'(d8),         64'd0);
    end
    in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 8'h56;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    check("mrst.new_valid8", 64'(out_valid8), 64'd1);
    check("mrst.new_d8",     64'(d8),         64'h70);
    check("mrst.new_par8",   64'(d_par8),     64'd1);

    // Back-to-back mixed traffic, checked by the per-cycle compare.
    for (int i = 0; i < 12; i++) begin
      pat = 8'(i);
      in_valid1 = (i % 3 != 2);
      a1 = pat[0]; b1 = pat[1]; c1 = pat[3];
      in_valid8 = (i % 4 != 3);
      a8 = 8'(i * 29); b8 = ~8'(i * 7); c8 = {pat[3:0], pat[7:4]} ^ 8'h5A;
      tick();
    end
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_three_xor_parity
